// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: 4x4 matrix keypad scanner with debounce and valid/ready output.
//   CLOCK_50    system clock
//   rst_n       asynchronous active-low reset
//   col_out     column drive, active-low, exactly one column low
//   row_in      row sense, active-low, asynchronous to CLOCK_50
//   key_code    key index {row, col}
//   key_valid   key_code holds an unconsumed key
//   key_ready   consumer accepts key_code when high together with key_valid
//   key_held    high while a debounced key is being held down
//   key_overrun one-cycle pulse when a debounced key is dropped (previous key unconsumed)
module keypad_scan_ctrl #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 20
) (
  input  logic       CLOCK_50,
  input  logic       rst_n,
  output logic [3:0] col_out,
  input  logic [3:0] row_in,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       key_held,
  output logic       key_overrun
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_SCANS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [1:0] ST_SCAN = 2'd0;
  localparam logic [1:0] ST_DEB  = 2'd1;
  localparam logic [1:0] ST_HELD = 2'd2;

  logic [3:0]       rs_meta, rs;
  logic [DIV_W-1:0] div;
  logic             tick;
  logic [1:0]       state;
  logic [1:0]       col;
  logic [1:0]       r, c;
  logic [CNT_W-1:0] dcnt, relcnt, dcnt_nxt, relcnt_nxt;
  logic             act;
  logic [1:0]       arow;
  logic             emit;
  logic [3:0]       emit_code;

  // Rows are asynchronous; two flops before anything looks at them.
  // Idle level is all-high (no key).
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      rs_meta <= 4'b1111;
      rs      <= 4'b1111;
    end else begin
      rs_meta <= row_in;
      rs      <= rs_meta;
    end
  end

  assign tick       = (div == DIV_LAST);
  assign act        = ~&rs;
  assign dcnt_nxt   = dcnt + 1'b1;
  assign relcnt_nxt = relcnt + 1'b1;
  assign col_out    = ~(4'b0001 << col);
  assign key_held   = (state == ST_HELD);

  // Lowest-numbered active row wins when several are low.
  always_comb begin
    arow = 2'd0;
    if      (!rs[0]) arow = 2'd0;
    else if (!rs[1]) arow = 2'd1;
    else if (!rs[2]) arow = 2'd2;
    else if (!rs[3]) arow = 2'd3;
  end

  // A key is emitted on the tick that completes the debounce. With a
  // single-sample debounce that is the detecting tick itself, so the
  // code comes straight from the live row/column rather than r/c.
  always_comb begin
    emit      = 1'b0;
    emit_code = {r, c};
    if (tick) begin
      case (state)
        ST_SCAN: if (act && DEBOUNCE_SCANS == 1) begin
          emit      = 1'b1;
          emit_code = {arow, col};
        end
        ST_DEB: if (act && arow == r && dcnt_nxt == CNT_DONE) emit = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      div    <= '0;
      state  <= ST_SCAN;
      col    <= 2'd0;
      r      <= 2'd0;
      c      <= 2'd0;
      dcnt   <= '0;
      relcnt <= '0;
    end else begin
      div <= tick ? '0 : div + 1'b1;
      if (tick) begin
        case (state)
          ST_SCAN: begin
            if (act) begin
              r    <= arow;
              c    <= col;
              dcnt <= CNT_ONE;
              if (DEBOUNCE_SCANS == 1) begin
                state  <= ST_HELD;
                relcnt <= '0;
              end else begin
                state <= ST_DEB;
              end
            end else begin
              col <= col + 2'd1;
            end
          end
          ST_DEB: begin
            // Column is still parked on c, so rs reflects only that column.
            if (act && arow == r) begin
              dcnt <= dcnt_nxt;
              if (dcnt_nxt == CNT_DONE) begin
                state  <= ST_HELD;
                relcnt <= '0;
              end
            end else begin
              state <= ST_SCAN;
            end
          end
          ST_HELD: begin
            if (act) begin
              relcnt <= '0;
            end else if (relcnt_nxt == CNT_DONE) begin
              state  <= ST_SCAN;
              relcnt <= '0;
              col    <= c + 2'd1;
            end else begin
              relcnt <= relcnt_nxt;
            end
          end
          default: state <= ST_SCAN;
        endcase
      end
    end
  end

  // Output register: an accept and a new emit in the same cycle replace
  // the old key without a gap; an emit against an unconsumed key is dropped.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      key_code    <= 4'd0;
      key_valid   <= 1'b0;
      key_overrun <= 1'b0;
    end else begin
      key_overrun <= 1'b0;
      if (emit) begin
        if (!key_valid || key_ready) begin
          key_code  <= emit_code;
          key_valid <= 1'b1;
        end else begin
          key_overrun <= 1'b1;
        end
      end else if (key_valid && key_ready) begin
        key_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
module tb_keypad_scan_ctrl;
  localparam int SD = 4;
  localparam int DS = 3;

  logic       CLOCK_50 = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] col_out, row_in, key_code;
  logic       key_valid, key_ready, key_held, key_overrun;
  logic [15:0] pressed;

  int n_chk = 0;
  int n_pass = 0;
  int ovr_cnt = 0;
  logic [3:0] acc_q[$];
  logic [3:0] exp_q[$];

  keypad_scan_ctrl #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DS)) dut (
    .CLOCK_50(CLOCK_50), .rst_n(rst_n), .col_out(col_out), .row_in(row_in),
    .key_code(key_code), .key_valid(key_valid), .key_ready(key_ready),
    .key_held(key_held), .key_overrun(key_overrun)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Keypad matrix: a row reads low when a pressed key sits on a driven column.
  always_comb begin
    row_in = 4'b1111;
    for (int rr = 0; rr < 4; rr++)
      row_in[rr] = ~|(pressed[rr*4 +: 4] & ~col_out);
  end

  // Consumer-side observer: records every accepted key and overrun pulse.
  always @(negedge CLOCK_50) begin
    #2;
    if (rst_n) begin
      if (key_valid && key_ready) acc_q.push_back(key_code);
      if (key_overrun) ovr_cnt++;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic wait_valid(input int bound, output bit ok);
    int i = 0;
    while (key_valid !== 1'b1 && i < bound) begin @(negedge CLOCK_50); i++; end
    ok = (key_valid === 1'b1);
  endtask

  task automatic wait_unheld(input int bound, output bit ok);
    int i = 0;
    while (key_held !== 1'b0 && i < bound) begin @(negedge CLOCK_50); i++; end
    ok = (key_held === 1'b0);
  endtask

  // Stops at the first negedge after col_out newly takes value v.
  task automatic wait_col(input logic [3:0] v, input int bound, output bit ok);
    int i = 0;
    while (col_out === v && i < bound) begin @(negedge CLOCK_50); i++; end
    while (col_out !== v && i < bound) begin @(negedge CLOCK_50); i++; end
    ok = (col_out === v);
  endtask

  task automatic test_reset;
    bit ok;
    pressed = '0; key_ready = 1'b0; rst_n = 1'b0;
    cyc(3);
    n_chk++; if (col_out !== 4'b1110) $display("FAIL reset_col_out: got %b want 1110", col_out); else n_pass++;
    n_chk++; if (key_valid !== 1'b0) $display("FAIL reset_key_valid: got %b want 0", key_valid); else n_pass++;
    n_chk++; if (key_code !== 4'd0) $display("FAIL reset_key_code: got %0d want 0", key_code); else n_pass++;
    n_chk++; if (key_held !== 1'b0) $display("FAIL reset_key_held: got %b want 0", key_held); else n_pass++;
    n_chk++; if (key_overrun !== 1'b0) $display("FAIL reset_key_overrun: got %b want 0", key_overrun); else n_pass++;
    ok = 1'b1;
  endtask

  task automatic test_idle_rotation;
    logic [3:0] exp_col [5];
    exp_col[0] = 4'b1110; exp_col[1] = 4'b1101; exp_col[2] = 4'b1011;
    exp_col[3] = 4'b0111; exp_col[4] = 4'b1110;
    rst_n = 1'b1;  // released on a negedge, divider starts at 0
    for (int i = 0; i < 20; i++) begin
      n_chk++; if (col_out !== exp_col[i/4]) $display("FAIL idle_col[%0d]: got %b want %b", i, col_out, exp_col[i/4]); else n_pass++;
      n_chk++; if (key_valid !== 1'b0) $display("FAIL idle_valid[%0d]: got %b want 0", i, key_valid); else n_pass++;
      @(negedge CLOCK_50);
    end
  endtask

  task automatic test_clean_press;
    bit ok; int ovr0;
    key_ready = 1'b0; acc_q.delete(); ovr0 = ovr_cnt;
    pressed = 16'h1 << 9;
    wait_valid(80, ok);
    n_chk++; if (!ok) $display("FAIL clean_valid_timeout: got valid=%b want 1", key_valid); else n_pass++;
    n_chk++; if (key_code !== 4'd9) $display("FAIL clean_code: got %0d want 9", key_code); else n_pass++;
    n_chk++; if (key_held !== 1'b1) $display("FAIL clean_held: got %b want 1", key_held); else n_pass++;
    cyc(40);
    n_chk++; if (key_valid !== 1'b1 || key_code !== 4'd9) $display("FAIL clean_hold_stable: got valid=%b code=%0d want valid=1 code=9", key_valid, key_code); else n_pass++;
    n_chk++; if (ovr_cnt != ovr0) $display("FAIL clean_no_reemit: got %0d overruns want 0", ovr_cnt - ovr0); else n_pass++;
    n_chk++; if (key_held !== 1'b1) $display("FAIL clean_still_held: got %b want 1", key_held); else n_pass++;
    pressed = '0;
    wait_unheld(60, ok);
    n_chk++; if (!ok) $display("FAIL clean_release_timeout: got held=%b want 0", key_held); else n_pass++;
    n_chk++; if (col_out !== 4'b1011) $display("FAIL clean_resume_col: got %b want 1011", col_out); else n_pass++;
    key_ready = 1'b1;
    @(negedge CLOCK_50);
    key_ready = 1'b0;
    n_chk++; if (key_valid !== 1'b0) $display("FAIL clean_accept_drop: got %b want 0", key_valid); else n_pass++;
    n_chk++; if (acc_q.size() != 1 || acc_q[0] !== 4'd9) $display("FAIL clean_accepted: got n=%0d want n=1 code 9", acc_q.size()); else n_pass++;
  endtask

  task automatic test_bounce;
    bit ok;
    key_ready = 1'b1; acc_q.delete();
    wait_col(4'b1110, 40, ok);
    n_chk++; if (!ok) $display("FAIL bounce_col_timeout: got %b want 1110", col_out); else n_pass++;
    // Short contact spanning two ticks: fewer than three agreeing samples.
    pressed = 16'h1;
    cyc(6);
    pressed = '0;
    cyc(20);
    n_chk++; if (acc_q.size() != 0 || key_valid !== 1'b0) $display("FAIL bounce_rejected: got n=%0d valid=%b want n=0 valid=0", acc_q.size(), key_valid); else n_pass++;
    pressed = 16'h1;
    wait_valid(80, ok);
    n_chk++; if (!ok) $display("FAIL bounce_valid_timeout: got valid=%b want 1", key_valid); else n_pass++;
    n_chk++; if (key_code !== 4'd0) $display("FAIL bounce_code: got %0d want 0", key_code); else n_pass++;
    cyc(20);
    pressed = '0;
    wait_unheld(60, ok);
    cyc(4);
    n_chk++; if (acc_q.size() != 1 || acc_q[0] !== 4'd0) $display("FAIL bounce_single: got n=%0d want n=1 code 0", acc_q.size()); else n_pass++;
    key_ready = 1'b0;
  endtask

  task automatic test_overrun;
    bit ok; int ovr0;
    key_ready = 1'b0; ovr0 = ovr_cnt;
    pressed = 16'h1 << 5;
    wait_valid(80, ok);
    n_chk++; if (!ok || key_code !== 4'd5) $display("FAIL ovr_first: got valid=%b code=%0d want valid=1 code=5", key_valid, key_code); else n_pass++;
    cyc(10);
    pressed = '0;
    wait_unheld(60, ok);
    pressed = 16'h1 << 10;
    for (int i = 0; i < 80 && ovr_cnt == ovr0; i++) @(negedge CLOCK_50);
    n_chk++; if (ovr_cnt == ovr0) $display("FAIL ovr_pulse_timeout: got 0 pulses want 1"); else n_pass++;
    n_chk++; if (key_valid !== 1'b1 || key_code !== 4'd5) $display("FAIL ovr_kept: got valid=%b code=%0d want valid=1 code=5", key_valid, key_code); else n_pass++;
    pressed = '0;
    wait_unheld(60, ok);
    cyc(20);
    n_chk++; if (ovr_cnt != ovr0 + 1) $display("FAIL ovr_once: got %0d pulses want 1", ovr_cnt - ovr0); else n_pass++;
    key_ready = 1'b1;
    n_chk++; if (key_valid !== 1'b1) $display("FAIL ovr_pre_accept: got %b want 1", key_valid); else n_pass++;
    @(negedge CLOCK_50);
    key_ready = 1'b0;
    n_chk++; if (key_valid !== 1'b0) $display("FAIL ovr_accept_drop: got %b want 0", key_valid); else n_pass++;
  endtask

  task automatic test_back_to_back;
    bit ok; int ovr0;
    key_ready = 1'b0; ovr0 = ovr_cnt;
    pressed = 16'h1 << 7;
    wait_valid(80, ok);
    n_chk++; if (!ok || key_code !== 4'd7) $display("FAIL b2b_first: got valid=%b code=%0d want valid=1 code=7", key_valid, key_code); else n_pass++;
    cyc(5);
    pressed = '0;
    wait_unheld(60, ok);
    wait_col(4'b0111, 60, ok);
    n_chk++; if (!ok) $display("FAIL b2b_col_timeout: got %b want 0111", col_out); else n_pass++;
    // Column 3 just became active: detect at +4, agree at +8, emit at +12.
    pressed = 16'h1 << 3;
    cyc(11);
    key_ready = 1'b1;
    n_chk++; if (key_valid !== 1'b1 || key_code !== 4'd7) $display("FAIL b2b_pending: got valid=%b code=%0d want valid=1 code=7", key_valid, key_code); else n_pass++;
    @(negedge CLOCK_50);
    key_ready = 1'b0;
    n_chk++; if (key_valid !== 1'b1 || key_code !== 4'd3) $display("FAIL b2b_replace: got valid=%b code=%0d want valid=1 code=3", key_valid, key_code); else n_pass++;
    n_chk++; if (ovr_cnt != ovr0) $display("FAIL b2b_no_overrun: got %0d pulses want 0", ovr_cnt - ovr0); else n_pass++;
    pressed = '0;
    wait_unheld(60, ok);
  endtask

  task automatic test_reset_mid_debounce;
    bit ok;
    key_ready = 1'b0;
    n_chk++; if (key_valid !== 1'b1) $display("FAIL rstmid_pending: got %b want 1", key_valid); else n_pass++;
    wait_col(4'b1011, 60, ok);
    pressed = 16'h1 << 6;
    cyc(6);
    rst_n = 1'b0;
    #1;
    n_chk++; if (col_out !== 4'b1110) $display("FAIL rstmid_col: got %b want 1110", col_out); else n_pass++;
    n_chk++; if (key_valid !== 1'b0) $display("FAIL rstmid_valid: got %b want 0", key_valid); else n_pass++;
    n_chk++; if (key_held !== 1'b0) $display("FAIL rstmid_held: got %b want 0", key_held); else n_pass++;
    @(negedge CLOCK_50);
    rst_n = 1'b1;
    // Scan to column 2 (8 cycles), then three agreeing ticks at 12, 16, 20.
    cyc(19);
    n_chk++; if (key_valid !== 1'b0) $display("FAIL rstmid_early: got %b want 0", key_valid); else n_pass++;
    cyc(1);
    n_chk++; if (key_valid !== 1'b1 || key_code !== 4'd6) $display("FAIL rstmid_redebounce: got valid=%b code=%0d want valid=1 code=6", key_valid, key_code); else n_pass++;
    pressed = '0;
    wait_unheld(60, ok);
    key_ready = 1'b1;
    @(negedge CLOCK_50);
    key_ready = 1'b0;
  endtask

  task automatic rnd_hold(input int n);
    repeat (n) begin
      key_ready = 1'($urandom_range(0, 1));
      @(negedge CLOCK_50);
    end
  endtask

  // Reference: every press held well past the debounce window yields exactly
  // that key once, in press order; short glitches yield nothing.
  task automatic test_random;
    int ovr0; int k; int g;
    acc_q.delete(); exp_q.delete(); ovr0 = ovr_cnt;
    for (int it = 0; it < 12; it++) begin
      k = $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 1) begin
        g = $urandom_range(0, 15);
        pressed = 16'h1 << g;
        rnd_hold(1);
        pressed = '0;
        rnd_hold(8);
      end
      pressed = 16'h1 << k;
      exp_q.push_back(4'(k));
      rnd_hold($urandom_range(60, 90));
      pressed = '0;
      rnd_hold($urandom_range(30, 50));
    end
    key_ready = 1'b1;
    cyc(5);
    key_ready = 1'b0;
    n_chk++; if (acc_q.size() != exp_q.size()) $display("FAIL rand_count: got %0d want %0d", acc_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size(); i++) begin
      n_chk++;
      if (i >= acc_q.size()) $display("FAIL rand_key[%0d]: got none want %0d", i, exp_q[i]);
      else if (acc_q[i] !== exp_q[i]) $display("FAIL rand_key[%0d]: got %0d want %0d", i, acc_q[i], exp_q[i]);
      else n_pass++;
    end
    n_chk++; if (ovr_cnt != ovr0) $display("FAIL rand_overrun: got %0d pulses want 0", ovr_cnt - ovr0); else n_pass++;
  endtask

  initial begin
    pressed = '0;
    key_ready = 1'b0;
    @(negedge CLOCK_50);
    test_reset;
    test_idle_rotation;
    test_clean_press;
    test_bounce;
    test_overrun;
    test_back_to_back;
    test_reset_mid_debounce;
    test_random;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
